// File: rtl/popcount_pkg.sv
// Shared constants and FSM state type for the unary (thermometer) serial transmitter.
package popcount_pkg;

  localparam int unsigned N  = 18;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

endpackage

// File: rtl/therm_encoder.sv
// Combinational count-to-thermometer encoder: clamps the count to N and flags saturation.
module therm_encoder #(
  parameter int unsigned N  = 18,
  parameter int unsigned CW = 5
) (
  input  logic [CW-1:0] count,
  output logic [N-1:0]  mask,
  output logic          sat
);

  logic [CW-1:0] clamped;

  always_comb begin
    sat     = 32'(count) > N;
    clamped = sat ? CW'(N) : count;
    mask    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      mask[i] = i < 32'(clamped);
    end
  end

endmodule

// File: rtl/popcount18_unary_tx.sv
// Accepts a ones-count and streams it out as an N-bit unary frame, LSB first, with
// valid/ready handshaking on both sides and a registered parallel thermometer copy.
module popcount18_unary_tx #(
  parameter int unsigned N  = popcount_pkg::N,
  parameter int unsigned CW = popcount_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_count,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_bit,
  output logic          out_last,
  output logic [N-1:0]  out_therm,
  output logic          out_sat
);

  import popcount_pkg::*;

  state_e        state_q;
  logic [CW-1:0] idx_q;
  logic [N-1:0]  shreg_q;
  logic [N-1:0]  therm_q;
  logic          sat_q;

  logic [N-1:0]  enc_mask;
  logic          enc_sat;
  logic          at_last;

  therm_encoder #(
    .N  (N),
    .CW (CW)
  ) u_therm_encoder (
    .count (in_count),
    .mask  (enc_mask),
    .sat   (enc_sat)
  );

  assign at_last = idx_q == CW'(N - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      therm_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_q <= enc_mask;
            therm_q <= enc_mask;
            sat_q   <= enc_sat;
            idx_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            shreg_q <= shreg_q >> 1;
            // Index parks at N-1 on the final beat; the next accept clears it.
            if (at_last) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = state_q == IDLE;
    out_valid = state_q == SHIFT;
    out_bit   = out_valid & shreg_q[0];
    out_last  = out_valid & at_last;
    out_therm = therm_q;
    out_sat   = sat_q;
  end

endmodule

// File: tb/tb_popcount18_unary_tx.sv
// Randomized bench for popcount18_unary_tx against a frame-level reference model.
module tb_popcount18_unary_tx;

  localparam int N  = 18;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_count = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_bit;
  logic          out_last;
  logic [N-1:0]  out_therm;
  logic          out_sat;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  popcount18_unary_tx #(
    .N  (N),
    .CW (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_therm (out_therm),
    .out_sat   (out_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Sends one count and receives the whole frame; stall randomizes out_ready,
  // hold_valid keeps in_valid asserted throughout the frame.
  task automatic send(input int cnt, input bit stall, input bit hold_valid);
    int          c;
    int          guard;
    int          beats;
    int          ones;
    int          lasts;
    int          cycles;
    bit          stalled;
    logic        prev_bit;
    logic        prev_last;
    logic [31:0] exp_therm;
    c         = (cnt > N) ? N : cnt;
    exp_therm = (32'd1 << c) - 32'd1;

    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("idle_timeout", 32'(in_ready), 32'd1);
      return;
    end

    in_valid = 1'b1;
    in_count = CW'(cnt);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    check("latency1_valid", 32'(out_valid), 32'd1);
    check("therm_on_accept", 32'(out_therm), exp_therm);
    check("sat_on_accept", 32'(out_sat), 32'(cnt > N));

    beats   = 0;
    ones    = 0;
    lasts   = 0;
    cycles  = 0;
    stalled = 1'b0;
    while (beats < N && cycles < 2000) begin
      if (stalled) begin
        check("stall_bit_stable", 32'(out_bit), 32'(prev_bit));
        check("stall_last_stable", 32'(out_last), 32'(prev_last));
      end
      check("busy_not_ready", 32'(in_ready), 32'd0);
      out_ready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
      if (out_ready) begin
        check("beat_bit", 32'(out_bit), 32'(beats < c));
        check("beat_last", 32'(out_last), 32'(beats == N - 1));
        ones   += int'(out_bit);
        lasts  += int'(out_last);
        beats++;
        stalled = 1'b0;
      end else begin
        prev_bit  = out_bit;
        prev_last = out_last;
        stalled   = 1'b1;
      end
      @(negedge clk);
      cycles++;
    end
    check("frame_beats", 32'(beats), 32'(N));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("idle_after_last", 32'(in_ready), 32'd1);
    check("no_valid_after_last", 32'(out_valid), 32'd0);
    check("frame_popcount", 32'(ones), 32'(c));
    check("frame_one_last", 32'(lasts), 32'd1);
    check("therm_held", 32'(out_therm), exp_therm);
    check("sat_held", 32'(out_sat), 32'(cnt > N));
  endtask

  initial begin
    #12;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_therm", 32'(out_therm), 32'd0);
    check("reset_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(in_ready), 32'd1);

    send(5, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    send(18, 1'b0, 1'b0);
    send(31, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    send(9, 1'b1, 1'b0);
    send(19, 1'b1, 1'b1);

    // Reset in the middle of a count-12 frame, then a clean count-2 frame.
    in_valid = 1'b1;
    in_count = CW'(12);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_bit", 32'(out_bit), 32'd0);
    check("async_rst_last", 32'(out_last), 32'd0);
    check("async_rst_therm", 32'(out_therm), 32'd0);
    check("async_rst_sat", 32'(out_sat), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 32'(in_ready), 32'd1);
    check("rst_release_no_resume", 32'(out_valid), 32'd0);
    send(2, 1'b0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      send(int'($urandom_range(31, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
